// File: rtl/spi_instr_decoder.sv
// Decodes two-byte SPI frames {rw, hl, addr} + data into single-cycle register
// read/write strobes on the peripheral clock; read data returns via data_out.
module spi_instr_decoder #(
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic [ADDR_W-1:0] addr,
    output logic              hl,
    output logic              read,
    output logic              write,
    output logic [7:0]        data_write,
    input  logic [7:0]        data_read
);

    typedef enum logic {CMD, DATA} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] bs_sync, cs_sync;
    logic                   bs_prev, cs_prev;
    logic                   byte_evt, cs_evt;
    logic [7:0]             byte_q;
    logic                   rw, rw_nx;
    logic [ADDR_W-1:0]      addr_nx;
    logic                   hl_nx, read_nx, write_nx, rd_pend;
    logic [7:0]             dw_nx;

    wire bs_s = bs_sync[SYNC_STAGES-1];
    wire cs_s = cs_sync[SYNC_STAGES-1];

    // Both events are registered from equal-depth chains so a simultaneous
    // cs_n rise and byte arrival land in the same cycle and the abort wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            bs_sync  <= '0;
            cs_sync  <= '0;
            bs_prev  <= 1'b0;
            cs_prev  <= 1'b0;
            byte_evt <= 1'b0;
            cs_evt   <= 1'b0;
            byte_q   <= '0;
        end else begin
            bs_sync  <= {bs_sync[SYNC_STAGES-2:0], byte_sync};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            bs_prev  <= bs_s;
            cs_prev  <= cs_s;
            byte_evt <= bs_s & ~bs_prev;
            cs_evt   <= cs_s & ~cs_prev;
            if (bs_s & ~bs_prev)
                byte_q <= data_in;
        end
    end

    always_comb begin
        state_nx = state;
        rw_nx    = rw;
        addr_nx  = addr;
        hl_nx    = hl;
        dw_nx    = data_write;
        read_nx  = 1'b0;
        write_nx = 1'b0;
        if (cs_evt) begin
            state_nx = CMD;
        end else if (byte_evt) begin
            case (state)
                CMD: begin
                    rw_nx    = byte_q[7];
                    hl_nx    = byte_q[6];
                    addr_nx  = ADDR_W'(byte_q[5:0]);
                    read_nx  = ~byte_q[7];
                    state_nx = DATA;
                end
                DATA: begin
                    if (rw) begin
                        dw_nx    = byte_q;
                        write_nx = 1'b1;
                    end
                    state_nx = CMD;
                end
                default: state_nx = CMD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CMD;
            rw         <= 1'b0;
            addr       <= '0;
            hl         <= 1'b0;
            data_write <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            rd_pend    <= 1'b0;
            data_out   <= '0;
        end else begin
            state      <= state_nx;
            rw         <= rw_nx;
            addr       <= addr_nx;
            hl         <= hl_nx;
            data_write <= dw_nx;
            read       <= read_nx;
            write      <= write_nx;
            // Register file answers the cycle after the read strobe.
            rd_pend    <= read;
            if (rd_pend)
                data_out <= data_read;
        end
    end

endmodule

// File: tb/tb_spi_instr_decoder.sv
// Directed bench for spi_instr_decoder: table of whole frames plus hand-written
// sequences for abort, held byte_sync, reset mid-frame and sync latency.
module tb_spi_instr_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [5:0] addr;
    logic       hl;
    logic       read;
    logic       write;
    logic [7:0] data_write;
    logic [7:0] data_read;

    spi_instr_decoder #(.ADDR_W(6), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .byte_sync(byte_sync),
        .data_in(data_in), .data_out(data_out), .addr(addr), .hl(hl),
        .read(read), .write(write), .data_write(data_write),
        .data_read(data_read)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          rcnt = 0;
    int          wcnt = 0;
    int          both = 0;
    logic [15:0] wlog[$];

    always @(negedge clk) begin
        if (write) begin
            wcnt++;
            wlog.push_back({2'b00, addr, data_write});
        end
        if (read) rcnt++;
        if (read && write) both++;
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        logic [7:0] drd;
        int         er;
        int         ew;
        logic [5:0] eaddr;
        logic       ehl;
        logic [7:0] edw;
        logic [7:0] edout;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        data_in   = b;
        byte_sync = 1'b1;
        repeat (6) @(posedge clk);
        #1 byte_sync = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic cs_frame_end();
        @(posedge clk); #1 cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 cs_n = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    int r0, w0, q0, lat;

    initial begin
        vecs[0] = '{cmd:8'h85, dat:8'h3C, drd:8'h00, er:0, ew:1, eaddr:6'h05, ehl:1'b0, edw:8'h3C, edout:8'h00};
        vecs[1] = '{cmd:8'h45, dat:8'h00, drd:8'hA7, er:1, ew:0, eaddr:6'h05, ehl:1'b1, edw:8'h3C, edout:8'hA7};
        vecs[2] = '{cmd:8'hC3, dat:8'h5A, drd:8'h11, er:0, ew:1, eaddr:6'h03, ehl:1'b1, edw:8'h5A, edout:8'hA7};
        vecs[3] = '{cmd:8'h3F, dat:8'h77, drd:8'h6B, er:1, ew:0, eaddr:6'h3F, ehl:1'b0, edw:8'h5A, edout:8'h6B};

        rst = 1'b1; cs_n = 1'b1; byte_sync = 1'b0; data_in = 8'h00; data_read = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_hl", 32'(hl), 32'h0);
        chk("rst_strobes", 32'({read, write}), 32'h0);
        chk("rst_dw", 32'(data_write), 32'h0);
        chk("rst_dout", 32'(data_out), 32'h0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 cs_n = 1'b0;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 4; i++) begin
            r0 = rcnt; w0 = wcnt;
            data_read = vecs[i].drd;
            send_byte(vecs[i].cmd);
            send_byte(vecs[i].dat);
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("v%0d_reads", i), 32'(rcnt - r0), 32'(vecs[i].er));
            chk($sformatf("v%0d_writes", i), 32'(wcnt - w0), 32'(vecs[i].ew));
            chk($sformatf("v%0d_addr", i), 32'(addr), 32'(vecs[i].eaddr));
            chk($sformatf("v%0d_hl", i), 32'(hl), 32'(vecs[i].ehl));
            chk($sformatf("v%0d_dw", i), 32'(data_write), 32'(vecs[i].edw));
            chk($sformatf("v%0d_dout", i), 32'(data_out), 32'(vecs[i].edout));
        end

        // Back-to-back frames inside one CS frame
        w0 = wcnt; q0 = wlog.size();
        send_byte(8'h81); send_byte(8'h01);
        send_byte(8'h82); send_byte(8'h02);
        repeat (4) @(posedge clk);
        chk("b2b_writes", 32'(wcnt - w0), 32'd2);
        chk("b2b_first", 32'((wlog.size() > q0) ? wlog[q0] : 16'hFFFF), 32'h0101);
        chk("b2b_second", 32'((wlog.size() > q0 + 1) ? wlog[q0+1] : 16'hFFFF), 32'h0202);
        cs_frame_end();

        // Abort between command and data byte
        w0 = wcnt;
        send_byte(8'h81);
        cs_frame_end();
        // cs_n rise and byte arrival in the same cycle: byte must be dropped
        send_byte(8'h81);
        @(posedge clk); #1;
        cs_n = 1'b1; data_in = 8'h22; byte_sync = 1'b1;
        repeat (6) @(posedge clk);
        #1 byte_sync = 1'b0;
        repeat (6) @(posedge clk);
        #1 cs_n = 1'b0;
        repeat (4) @(posedge clk);
        chk("abort_no_write", 32'(wcnt - w0), 32'd0);
        q0 = wlog.size();
        send_byte(8'h82); send_byte(8'h11);
        repeat (4) @(posedge clk);
        chk("abort_next_writes", 32'(wcnt - w0), 32'd1);
        chk("abort_next_val", 32'((wlog.size() > q0) ? wlog[q0] : 16'hFFFF), 32'h0211);
        cs_frame_end();

        // byte_sync held high for 20 clk: one read only
        r0 = rcnt; w0 = wcnt;
        @(posedge clk); #1;
        data_in = 8'h07; byte_sync = 1'b1;
        repeat (20) @(posedge clk);
        #1 byte_sync = 1'b0;
        repeat (6) @(posedge clk);
        chk("held_reads", 32'(rcnt - r0), 32'd1);
        send_byte(8'h00);
        repeat (4) @(posedge clk);
        chk("held_after_data", 32'({16'(rcnt - r0), 16'(wcnt - w0)}), 32'h0001_0000);
        cs_frame_end();

        // Reset between bytes
        w0 = wcnt;
        send_byte(8'h84);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_addr", 32'(addr), 32'h0);
        chk("mid_rst_hl", 32'(hl), 32'h0);
        chk("mid_rst_strobes", 32'({read, write}), 32'h0);
        chk("mid_rst_dw", 32'(data_write), 32'h0);
        chk("mid_rst_dout", 32'(data_out), 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        send_byte(8'h99);
        repeat (4) @(posedge clk);
        chk("mid_rst_no_write", 32'(wcnt - w0), 32'd0);
        chk("mid_rst_as_cmd", 32'(addr), 32'h19);
        cs_frame_end();

        // Sync latency: read strobe SYNC_STAGES+2 cycles after byte_sync rises
        data_read = 8'hC4;
        lat = 0;
        @(posedge clk); #1;
        data_in = 8'h4A; byte_sync = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (read && lat == 0) lat = k;
        end
        chk("sync_latency", 32'(lat), 32'd4);
        byte_sync = 1'b0;
        repeat (6) @(posedge clk);
        send_byte(8'h00);
        repeat (4) @(posedge clk);
        chk("latency_dout", 32'(data_out), 32'hC4);
        chk("never_both", 32'(both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
